// File: rtl/z80_mem_arb_if.sv
// z80_mem_arb_if: Z80 bus, PicoRV32 memory port and shared RAM port bundled for the arbiter
interface z80_mem_arb_if #(parameter int ADDR_W = 16);
    logic              z80_mreq;
    logic              z80_we;
    logic [ADDR_W-1:0] z80_addr;
    logic [7:0]        z80_wdata;
    logic [7:0]        z80_rdata;
    logic              z80_wait_n;
    logic              rv_valid;
    logic [3:0]        rv_wstrb;
    logic [ADDR_W-1:0] rv_addr;
    logic [31:0]       rv_wdata;
    logic              rv_ready;
    logic [31:0]       rv_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  z80_mreq, z80_we, z80_addr, z80_wdata, rv_valid, rv_wstrb, rv_addr, rv_wdata, mem_rdata,
        output z80_rdata, z80_wait_n, rv_ready, rv_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output z80_mreq, z80_we, z80_addr, z80_wdata, rv_valid, rv_wstrb, rv_addr, rv_wdata, mem_rdata,
        input  z80_rdata, z80_wait_n, rv_ready, rv_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/z80_mem_arb.sv
// z80_mem_arb: alternating arbiter sharing one byte-wide 1-cycle BRAM between the Z80 and PicoRV32
module z80_mem_arb #(
    parameter int ADDR_W = 16
) (
    input logic            clk,
    input logic            resetn,
    z80_mem_arb_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC, CAPT, Z_HOLD} state_t;

    state_t            state, state_nx;
    logic              served, grant_rv, last_rv, acc_we;
    logic              z_pend, r_pend, pick_rv, take;
    logic [ADDR_W-1:0] addr_sel;
    logic [7:0]        rv_byte;

    assign z_pend         = bus.z80_mreq && !served;
    assign r_pend         = bus.rv_valid && !bus.rv_ready;
    assign pick_rv        = r_pend && (!z_pend || !last_rv);
    assign take           = (state == IDLE) && (z_pend || r_pend);
    assign addr_sel       = pick_rv ? bus.rv_addr : bus.z80_addr;
    assign rv_byte        = bus.rv_wdata[{bus.rv_addr[1:0], 3'b000} +: 8];
    assign bus.z80_wait_n = !z_pend;
    assign bus.mem_en     = state == ACC;
    assign bus.mem_we     = (state == ACC) && acc_we;

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // next state: one access per grant, Z80 grants park in Z_HOLD until MREQ drops
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = take ? ACC : IDLE;
            ACC:     state_nx = CAPT;
            CAPT:    state_nx = grant_rv ? IDLE : Z_HOLD;
            Z_HOLD:  state_nx = bus.z80_mreq ? Z_HOLD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // grant latching, RAM port registers and read-data return
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            served        <= 1'b0;
            grant_rv      <= 1'b0;
            last_rv       <= 1'b1;
            acc_we        <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.z80_rdata <= '0;
            bus.rv_rdata  <= '0;
            bus.rv_ready  <= 1'b0;
        end else begin
            bus.rv_ready <= 1'b0;
            if (take) begin
                grant_rv      <= pick_rv;
                last_rv       <= pick_rv;
                bus.mem_addr  <= addr_sel;
                acc_we        <= pick_rv ? |bus.rv_wstrb : bus.z80_we;
                bus.mem_wdata <= pick_rv ? rv_byte : bus.z80_wdata;
            end
            if (state == CAPT && grant_rv) begin
                bus.rv_rdata <= {4{bus.mem_rdata}};
                bus.rv_ready <= 1'b1;
            end
            if (state == CAPT && !grant_rv) begin
                served <= 1'b1;
                if (!acc_we) bus.z80_rdata <= bus.mem_rdata;
            end
            if (state == Z_HOLD && !bus.z80_mreq) served <= 1'b0;
        end
    end
endmodule

// File: tb/tb_z80_mem_arb.sv
// tb_z80_mem_arb: directed checks of the Z80/PicoRV32 RAM arbiter against a behavioural BRAM
module tb_z80_mem_arb;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    int   base, n, nz, rat;
    bit   log_on = 1'b0;
    bit   glog[$];
    logic [15:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  ram [0:65535];

    z80_mem_arb_if #(.ADDR_W(16)) bus();

    z80_mem_arb #(.ADDR_W(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // clock
    always #5 clk = ~clk;

    // behavioural single-port BRAM, read-first, data one cycle after enable
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
                wr_addr <= bus.mem_addr;
                wr_data <= bus.mem_wdata;
            end
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // count RAM accesses and record which side owned each (1 = Z80 at 0x0010)
    always @(posedge clk) begin
        if (bus.mem_en) begin
            en_cnt++;
            if (log_on) glog.push_back(bus.mem_addr == 16'h0010);
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // count clocks with z80_wait_n low, starting in the cycle MREQ was raised
    task automatic wait_z(output int cnt);
        cnt = 0;
        #1;
        while (bus.z80_wait_n === 1'b0 && cnt < 30) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // count clocks from driving rv_valid until rv_ready is seen
    task automatic wait_rv(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.rv_ready !== 1'b1 && cnt < 30);
    endtask

    // Z80 stall with the RV also requesting: returns stall clocks and the stall clock in which rv_ready appeared
    task automatic pair_z(input bit drop, output int cnt, output int ready_at);
        cnt = 0;
        ready_at = 0;
        #1;
        while (bus.z80_wait_n === 1'b0 && cnt < 30) begin
            cnt++;
            if (bus.rv_ready === 1'b1) begin
                ready_at = cnt;
                if (drop) bus.rv_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.z80_mreq = 0; bus.z80_we = 0; bus.z80_addr = '0; bus.z80_wdata = '0;
        bus.rv_valid = 0; bus.rv_wstrb = '0; bus.rv_addr = '0; bus.rv_wdata = '0;
        ram[16'h0010] = 8'hC3;
        ram[16'h0011] = 8'h5A;
        ram[16'h0020] = 8'h77;
        ram[16'h0102] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_rv_ready", {31'd0, bus.rv_ready}, 32'd0);
        chk("rst_wait_n", {31'd0, bus.z80_wait_n}, 32'd1);
        chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        chk("rst_z80_rdata", {24'd0, bus.z80_rdata}, 32'd0);
        chk("rst_rv_rdata", bus.rv_rdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Z80 read 0x0010, held for 10 clocks
        base = en_cnt;
        bus.z80_addr = 16'h0010; bus.z80_we = 1'b0; bus.z80_mreq = 1'b1;
        wait_z(n);
        chk("z_read_wait", n, 32'd3);
        chk("z_read_data", {24'd0, bus.z80_rdata}, 32'h0000_00C3);
        chk("z_read_one_acc", en_cnt - base, 32'd1);
        repeat (7) @(negedge clk);
        chk("z_hold_wait_n", {31'd0, bus.z80_wait_n}, 32'd1);
        chk("z_hold_one_acc", en_cnt - base, 32'd1);
        bus.z80_mreq = 1'b0;
        @(negedge clk);
        bus.z80_addr = 16'h0011; bus.z80_mreq = 1'b1;
        wait_z(n);
        chk("z_reissue_wait", n, 32'd3);
        chk("z_reissue_acc", en_cnt - base, 32'd2);
        chk("z_reissue_data", {24'd0, bus.z80_rdata}, 32'h0000_005A);
        bus.z80_mreq = 1'b0;
        @(negedge clk);

        // RV byte-lane write then read back
        bus.rv_addr = 16'h0102; bus.rv_wstrb = 4'b0100; bus.rv_wdata = 32'h00AB_0000; bus.rv_valid = 1'b1;
        wait_rv(n);
        chk("rv_wr_latency", n, 32'd3);
        chk("rv_wr_addr", {16'd0, wr_addr}, 32'h0000_0102);
        chk("rv_wr_data", {24'd0, wr_data}, 32'h0000_00AB);
        chk("rv_wr_ram", {24'd0, ram[16'h0102]}, 32'h0000_00AB);
        bus.rv_valid = 1'b0;
        @(negedge clk);
        chk("rv_wr_pulse", {31'd0, bus.rv_ready}, 32'd0);
        bus.rv_wstrb = 4'b0000; bus.rv_valid = 1'b1;
        wait_rv(n);
        chk("rv_rd_latency", n, 32'd3);
        chk("rv_rd_data", bus.rv_rdata, 32'hABAB_ABAB);
        bus.rv_valid = 1'b0;
        @(negedge clk);
        chk("rv_rd_pulse", {31'd0, bus.rv_ready}, 32'd0);

        // simultaneous pair out of reset: Z80 wins the tie
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        bus.z80_addr = 16'h0010; bus.z80_mreq = 1'b1;
        bus.rv_addr = 16'h0020; bus.rv_wstrb = 4'b0000; bus.rv_valid = 1'b1;
        wait_z(n);
        chk("tie1_z_wait", n, 32'd3);
        chk("tie1_rv_not_yet", {31'd0, bus.rv_ready}, 32'd0);
        chk("tie1_z_data", {24'd0, bus.z80_rdata}, 32'h0000_00C3);
        bus.z80_mreq = 1'b0;
        wait_rv(n);
        chk("tie1_rv_after_release", n, 32'd4);
        chk("tie1_rv_data", bus.rv_rdata, 32'h7777_7777);
        bus.rv_valid = 1'b0;
        @(negedge clk);

        // after a lone Z80 access the next tie goes to the RV
        bus.z80_mreq = 1'b1;
        wait_z(n);
        chk("lone_z_wait", n, 32'd3);
        bus.z80_mreq = 1'b0;
        @(negedge clk);
        bus.z80_addr = 16'h0011; bus.z80_mreq = 1'b1; bus.rv_valid = 1'b1;
        pair_z(1'b1, nz, rat);
        chk("tie2_rv_first", rat, 32'd4);
        chk("tie2_z_wait", nz, 32'd6);
        chk("tie2_z_data", {24'd0, bus.z80_rdata}, 32'h0000_005A);
        bus.z80_mreq = 1'b0;
        @(negedge clk);

        // RV continuously valid, four back-to-back Z80 reads
        glog.delete();
        log_on = 1'b1;
        bus.z80_addr = 16'h0010;
        bus.rv_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.z80_mreq = 1'b1;
            pair_z(1'b0, nz, rat);
            chk($sformatf("stream_z_wait%0d", i), nz, 32'd6);
            if (i == 3) begin
                log_on = 1'b0;
                bus.rv_valid = 1'b0;
            end
            bus.z80_mreq = 1'b0;
            @(negedge clk);
        end
        chk("stream_grants", glog.size(), 32'd8);
        for (int i = 0; i < 8 && i < glog.size(); i++)
            chk($sformatf("stream_alt%0d", i), {31'd0, glog[i]}, i % 2);
        @(negedge clk);

        // reset while an RV read is in its RAM access cycle
        bus.rv_addr = 16'h0020; bus.rv_valid = 1'b1;
        @(negedge clk);
        chk("mid_acc_en", {31'd0, bus.mem_en}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("mid_rst_rv_ready", {31'd0, bus.rv_ready}, 32'd0);
        chk("mid_rst_rv_rdata", bus.rv_rdata, 32'd0);
        chk("mid_rst_z80_rdata", {24'd0, bus.z80_rdata}, 32'd0);
        chk("mid_rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        @(negedge clk);
        chk("mid_rst_no_ready", {31'd0, bus.rv_ready}, 32'd0);
        resetn = 1'b1;
        wait_rv(n);
        chk("post_rst_latency", n, 32'd3);
        chk("post_rst_data", bus.rv_rdata, 32'h7777_7777);
        bus.rv_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/z80_mem_arb.md
# z80_mem_arb

Two-requester arbiter that shares one byte-wide single-port Z80 RAM block (BRAM, 1-cycle read latency) between the T80 CPU and the PicoRV32 supervisor. The PicoRV32 uses it to load CP/M images and move disk sectors while the Z80 runs. The Z80 side is stalled through WAIT_n until its access completes. The PicoRV32 side uses the native valid/ready memory handshake.

## Interface
- ADDR_W, 16: shared RAM byte-address width; memory depth is 2^ADDR_W bytes.
- clk  in  1  single system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- z80_mreq  in  1  Z80 memory request, active high (MREQ and RD, or MREQ and WR); held for the whole Z80 bus cycle.
- z80_we  in  1  1 = write, 0 = read; stable while z80_mreq is high.
- z80_addr  in  ADDR_W  Z80 byte address.
- z80_wdata  in  8  Z80 write data.
- z80_rdata  out  8  registered read data; holds its last value.
- z80_wait_n  out  1  low = stall the Z80.
- rv_valid  in  1  PicoRV32 request; held until rv_ready.
- rv_wstrb  in  4  nonzero = write.
- rv_addr  in  ADDR_W  byte address.
- rv_wdata  in  32  write data; the byte lane is selected by rv_addr[1:0].
- rv_ready  out  1  one-cycle completion pulse.
- rv_rdata  out  32  read byte replicated on all four lanes; valid while rv_ready is high.
- mem_en, mem_we  out  1 each  RAM port enable and write enable.
- mem_addr  out  ADDR_W; mem_wdata  out  8; mem_rdata  in  8  data is valid one cycle after the enable.

## Operation
- States:
  - IDLE: evaluate requests.
  - ACC: RAM port driven for the granted requester.
  - CAPT: read data returned, ready issued.
  - Z_HOLD: wait for the Z80 to release its request.
- Z80 pending = z80_mreq and not z80_served. RV pending = rv_valid in IDLE.
- Grant in IDLE:
  - Only one requester pending: grant it.
  - Both pending: grant the requester that was not granted last (last_grant register; reset value = RV, so the Z80 wins the first tie).
  - Update last_grant on every grant.
- Grant edge:
  - Register mem_addr, mem_we and mem_wdata from the winner.
  - Z80 write data = z80_wdata.
  - RV write data = rv_wdata[8*rv_addr[1:0] +: 8].
  - mem_we = z80_we for the Z80, or |rv_wstrb for the RV.
  - mem_en = 1 in ACC only.
- ACC always goes to CAPT. Writes also pass through CAPT so both access types have the same latency.
- CAPT, Z80 grant:
  - z80_rdata <= mem_rdata (reads only; unchanged on writes).
  - z80_served <= 1.
  - Next state Z_HOLD.
- CAPT, RV grant:
  - rv_rdata <= {4{mem_rdata}}.
  - rv_ready <= 1 for exactly one cycle.
  - Next state IDLE. rv_valid is not sampled in the cycle rv_ready is high.
- Z_HOLD: when z80_mreq = 0, clear z80_served and go to IDLE. A pending RV request is not served in Z_HOLD. This keeps the design simple; the Z80 releases within 1–2 clocks.
- z80_wait_n = !(z80_mreq && !z80_served). This output is combinational so that the wait asserts in the same cycle MREQ rises.
- Reset (async, any state):
  - State IDLE; z80_served = 0; last_grant = RV.
  - mem_en, mem_we, rv_ready = 0.
  - mem_addr, mem_wdata, z80_rdata, rv_rdata = 0.
  - z80_wait_n follows its equation (1 while z80_mreq = 0).
  - An in-flight access is abandoned. No ready is issued and no partial write completes unless mem_we had already been sampled by the RAM.

## Timing
- The request is seen in IDLE at edge E, so ACC starts at E+1.
- RAM sampled at E+1 → CAPT; rdata captured at E+2.
- RV: rv_ready is high in cycle E+2..E+3. Minimum latency is 3 clocks from rv_valid to rv_ready.
- Z80: z80_wait_n goes high after edge E+2. The Z80 sees at least 3 wait clocks, plus up to 3 more if the RV was mid-access when the request arrived.
- Worst-case Z80 stall with the RV continuously requesting = 6 clocks, guaranteed by alternation.
- Back-to-back RV requests: the next grant can occur in the cycle after rv_ready, giving one access per 4 clocks.
- z80_addr, z80_we and z80_wdata are sampled only at the grant edge. Later changes within the same bus cycle are ignored.

## Test plan
- Z80 read at 0x0010 (RAM holds 0xC3), RV idle → z80_wait_n low 3 clocks, z80_rdata = 0xC3 when wait_n rises, exactly one mem_en pulse.
- RV write rv_addr=0x0102, rv_wstrb=4'b0100, rv_wdata=0x00AB0000, then RV read 0x0102 → mem_wdata=0xAB at mem_addr=0x0102; read returns rv_rdata=0xABABABAB; each rv_ready is a 1-cycle pulse 3 clocks after valid.
- Z80 and RV request in the same cycle out of reset → Z80 granted first; RV rv_ready follows once the Z80 releases; the next simultaneous pair grants the RV first.
- Z80 holds z80_mreq for 10 clocks → exactly one RAM access; z80_served stays set until z80_mreq falls; the next Z80 request triggers a new access.
- RV continuously valid, Z80 issues 4 back-to-back reads → each Z80 stall ≤ 6 clocks; grants strictly alternate.
- Assert resetn=0 during ACC of an RV read → outputs reach their reset values immediately; no rv_ready; after release the RV re-request completes normally in 3 clocks.
